// File: rtl/i2c_led_regs.sv
// Register bank fed by the i2c slave byte stream: pointer byte, then auto-incrementing RGB triplets.
// Optional GLOBAL_BRIGHTNESS_EN adds a brightness register (pointer 8'hFF) and a registered scaling stage.
module i2c_led_regs #(
    parameter int NUM_LEDS = 3,
    parameter int IDX_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      addr_valid_i,
    input  logic                      data_valid_i,
    input  logic [7:0]                data_i,
    output logic [24*NUM_LEDS-1:0]    led_o,
    output logic                      commit_o,
    output logic                      frame_o,
    output logic [IDX_W-1:0]          idx_o
);

    typedef enum logic [1:0] {IDLE, PTR, DATA, DISCARD} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [IDX_W-1:0]          r_idx;
    logic [1:0]                r_cnt;
    logic [7:0]                r_b0;
    logic [7:0]                r_b1;
    logic [24*NUM_LEDS-1:0]    r_raw;
    logic                      r_commit;
    logic                      r_frame;

    logic                      w_byte;
    logic                      w_ptr_ok;
    logic                      w_ptr_bright;
    logic                      w_bsel;
    logic                      w_commit;

`ifdef GLOBAL_BRIGHTNESS_EN
    logic                      r_bsel;
    logic [7:0]                r_bright;
    logic [24*NUM_LEDS-1:0]    r_led_q;
    logic                      r_commit_q;
    logic                      r_frame_q;

    function automatic logic [7:0] scale(input logic [7:0] raw, input logic [7:0] br);
        logic [15:0] p;
        p = 16'(raw) * (16'(br) + 16'd1);
        return p[15:8];
    endfunction

    assign w_ptr_bright = (data_i == 8'hFF);
    assign w_bsel       = r_bsel;
`else
    assign w_ptr_bright = 1'b0;
    assign w_bsel       = 1'b0;
`endif

    // A start condition always wins over a byte arriving in the same cycle.
    assign w_byte   = data_valid_i && !addr_valid_i;
    assign w_ptr_ok = (32'(data_i) < 32'(NUM_LEDS));
    assign w_commit = (r_state == DATA) && w_byte && !w_bsel && (r_cnt == 2'd2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (addr_valid_i) begin
            w_state_nxt = PTR;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = IDLE;
                PTR:     if (data_valid_i) w_state_nxt = (w_ptr_ok || w_ptr_bright) ? DATA : DISCARD;
                DATA:    if (data_valid_i && w_bsel) w_state_nxt = DISCARD;
                DISCARD: w_state_nxt = DISCARD;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx    <= '0;
            r_cnt    <= '0;
            r_b0     <= '0;
            r_b1     <= '0;
            r_raw    <= '0;
            r_commit <= 1'b0;
            r_frame  <= 1'b0;
`ifdef GLOBAL_BRIGHTNESS_EN
            r_bsel   <= 1'b0;
            r_bright <= 8'hFF;
`endif
        end else begin
            r_commit <= w_commit;
            r_frame  <= w_commit && (r_idx == LAST_IDX);
            if (addr_valid_i) begin
                r_cnt <= '0;
`ifdef GLOBAL_BRIGHTNESS_EN
                r_bsel <= 1'b0;
`endif
            end else if (r_state == PTR && data_valid_i) begin
                r_cnt <= '0;
                if (w_ptr_ok) begin
                    r_idx <= IDX_W'(data_i);
                end
`ifdef GLOBAL_BRIGHTNESS_EN
                else if (w_ptr_bright) begin
                    r_bsel <= 1'b1;
                end
`endif
            end else if (r_state == DATA && data_valid_i) begin
                if (w_bsel) begin
`ifdef GLOBAL_BRIGHTNESS_EN
                    r_bright <= data_i;
                    r_bsel   <= 1'b0;
`endif
                end else begin
                    case (r_cnt)
                        2'd0: begin r_b0 <= data_i; r_cnt <= 2'd1; end
                        2'd1: begin r_b1 <= data_i; r_cnt <= 2'd2; end
                        default: begin
                            r_cnt <= '0;
                            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                        end
                    endcase
                    // Whole 24-bit word lands in one edge so no LED is ever half-updated.
                    for (int i = 0; i < NUM_LEDS; i++) begin
                        if (w_commit && r_idx == IDX_W'(i)) begin
                            r_raw[24*i +: 24] <= {r_b0, r_b1, data_i};
                        end
                    end
                end
            end
        end
    end

`ifdef GLOBAL_BRIGHTNESS_EN
    // Scaling stage: every channel is recomputed each cycle, so brightness writes need no commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led_q    <= '0;
            r_commit_q <= 1'b0;
            r_frame_q  <= 1'b0;
        end else begin
            r_commit_q <= r_commit;
            r_frame_q  <= r_frame;
            for (int c = 0; c < 3*NUM_LEDS; c++) begin
                r_led_q[8*c +: 8] <= scale(r_raw[8*c +: 8], r_bright);
            end
        end
    end

    assign led_o    = r_led_q;
    assign commit_o = r_commit_q;
    assign frame_o  = r_frame_q;
`else
    assign led_o    = r_raw;
    assign commit_o = r_commit;
    assign frame_o  = r_frame;
`endif

    assign idx_o = r_idx;

endmodule

// File: tb/tb_i2c_led_regs.sv
// Scoreboard bench for i2c_led_regs (default build, NUM_LEDS=3).
module tb_i2c_led_regs;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            av = 1'b0;
    logic            dv = 1'b0;
    logic [7:0]      din = 8'h00;
    logic [24*N-1:0] led;
    logic            commit;
    logic            frame;
    logic [7:0]      idx;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [24*N-1:0] led;
        logic            frame;
        logic [7:0]      idx;
    } exp_t;

    exp_t            q[$];
    logic [24*N-1:0] exp_bus = '0;

    i2c_led_regs #(.NUM_LEDS(N), .IDX_W(8)) dut (
        .clk(clk), .reset(rst_n), .addr_valid_i(av), .data_valid_i(dv), .data_i(din),
        .led_o(led), .commit_o(commit), .frame_o(frame), .idx_o(idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic a, input logic v, input logic [7:0] d);
        av = a; dv = v; din = d;
        @(negedge clk);
        av = 1'b0; dv = 1'b0;
    endtask

    task automatic bytes(input logic [7:0] b[]);
        foreach (b[i]) step(1'b0, 1'b1, b[i]);
    endtask

    task automatic exp_commit(input int i, input logic [23:0] w, input logic fr, input logic [7:0] nidx);
        exp_t e;
        exp_bus[24*i +: 24] = w;
        e.led = exp_bus; e.frame = fr; e.idx = nidx;
        q.push_back(e);
    endtask

    // Monitor: every commit pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (rst_n && commit) begin
            if (q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_commit: got commit with led %h, expected none", led);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("commit_led", 72'(led), 72'(e.led));
                chk("commit_frame", 72'(frame), 72'(e.frame));
                chk("commit_idx", 72'(idx), 72'(e.idx));
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_led", 72'(led), 72'h0);
        chk("rst_commit", 72'(commit), 72'h0);
        chk("rst_frame", 72'(frame), 72'h0);
        chk("rst_idx", 72'(idx), 72'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Bytes before any start are ignored in IDLE.
        bytes('{8'h00, 8'h12, 8'h34, 8'h56});
        chk("idle_led", 72'(led), 72'h0);

        step(1'b1, 1'b0, 8'h00);
        exp_commit(0, 24'hAB3684, 1'b0, 8'd1);
        exp_commit(1, 24'hD0255A, 1'b0, 8'd2);
        exp_commit(2, 24'h00770D, 1'b1, 8'd0);
        bytes('{8'h00, 8'hAB, 8'h36, 8'h84, 8'hD0, 8'h25, 8'h5A, 8'h00, 8'h77, 8'h0D});
        @(negedge clk);
        chk("seq1_led", 72'(led), 72'h00770D_D0255A_AB3684);
        chk("seq1_idx", 72'(idx), 72'h0);

        // Partial triplet dropped by a repeated start; block sits in PTR afterwards.
        step(1'b1, 1'b0, 8'h00);
        bytes('{8'h01, 8'hAB});
        chk("rs_idx", 72'(idx), 72'h1);
        step(1'b1, 1'b0, 8'h00);
        chk("rs_led", 72'(led), 72'h00770D_D0255A_AB3684);

        // Next byte is taken as a pointer straight away; triplets wrap 2 -> 0.
        exp_commit(2, 24'h112233, 1'b1, 8'd0);
        exp_commit(0, 24'h445566, 1'b0, 8'd1);
        bytes('{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
        @(negedge clk);
        chk("wrap_led", 72'(led), 72'h112233_D0255A_445566);

        step(1'b1, 1'b0, 8'h00);
        bytes('{8'h03, 8'h99, 8'h99, 8'h99});
        @(negedge clk);
        chk("oor_led", 72'(led), 72'h112233_D0255A_445566);
        chk("oor_idx", 72'(idx), 72'h1);

        // Start and byte in the same cycle: the byte is not used as the pointer.
        step(1'b1, 1'b1, 8'h02);
        exp_commit(0, 24'h010203, 1'b0, 8'd1);
        bytes('{8'h00, 8'h01, 8'h02, 8'h03});
        @(negedge clk);
        chk("oor2_led", 72'(led), 72'h112233_D0255A_010203);

        step(1'b1, 1'b0, 8'h00);
        bytes('{8'h02, 8'hAA, 8'hBB});
        chk("pre_rst_idx", 72'(idx), 72'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_led", 72'(led), 72'h0);
        chk("arst_idx", 72'(idx), 72'h0);
        chk("arst_commit", 72'(commit), 72'h0);
        chk("arst_frame", 72'(frame), 72'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bytes('{8'h00, 8'hCC, 8'hDD, 8'hEE});
        @(negedge clk);
        chk("post_rst_led", 72'(led), 72'h0);
        chk("post_rst_idx", 72'(idx), 72'h0);

        repeat (2) @(negedge clk);
        chk("queue_drained", 72'(q.size()), 72'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
